// File: rtl/key_step_input_pkg.sv
// Shared constants for the key stepping front end: FSM state codes and
// 50 MHz default timing.
package key_step_input_pkg;

    localparam logic [2:0] ST_RELEASED     = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_HELD         = 3'd2;
    localparam logic [2:0] ST_REPEAT       = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;  // 20 ms
    localparam int DEF_HOLD_CYC     = 25_000_000; // 500 ms
    localparam int DEF_REPEAT_CYC   = 5_000_000;  // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_step_input_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; the reset
// value lets the output start at the pin's idle level.
module key_step_input_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_step_input.sv
// Pushbutton front end: synchronizes and debounces a raw key, then emits
// single-cycle press, release and auto-repeat pulses.
module key_step_input
    import key_step_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk_50,
    input  logic rst,
    input  logic en,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam int MAX_CYC = max3(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);
    localparam logic          LOW_POL   = (ACTIVE_LOW != 0);

    logic          w_sync;
    logic          w_active;
    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [TW-1:0] r_timer;
    logic          w_stay_clr;
    logic          w_timer_clr;
    logic          w_press;
    logic          w_release;
    logic          w_repeat;
    logic          w_level_next;

    // Flops reset to the idle pin level so reset never looks like a press.
    key_step_input_sync_2ff #(
        .RST_VAL (LOW_POL)
    ) u_sync (
        .clk  (clk_50),
        .srst (rst),
        .i_d  (key_n),
        .o_q  (w_sync)
    );

    assign w_active = w_sync ^ LOW_POL;

    always_comb begin
        w_state_next = r_state;
        w_stay_clr   = 1'b0;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_repeat     = 1'b0;
        w_level_next = key_level;
        case (r_state)
            ST_RELEASED: begin
                if (w_active) w_state_next = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!w_active) begin
                    w_state_next = ST_RELEASED;
                end else if (r_timer == DEB_LAST) begin
                    w_state_next = ST_HELD;
                    w_press      = 1'b1;
                    w_level_next = 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_active) begin
                    w_state_next = ST_RELEASE_WAIT;
                end else if (r_timer == HOLD_LAST) begin
                    w_state_next = ST_REPEAT;
                    w_repeat     = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!w_active) begin
                    w_state_next = ST_RELEASE_WAIT;
                end else if (r_timer == REP_LAST) begin
                    w_repeat   = 1'b1;
                    w_stay_clr = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                // Bounce on release returns to HELD, restarting the hold delay.
                if (w_active) begin
                    w_state_next = ST_HELD;
                end else if (r_timer == DEB_LAST) begin
                    w_state_next = ST_RELEASED;
                    w_release    = 1'b1;
                    w_level_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_RELEASED;
            end
        endcase
    end

    assign w_timer_clr = w_stay_clr | (w_state_next != r_state);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state       <= ST_RELEASED;
            r_timer       <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_clr ? '0 : r_timer + TW'(1);
            key_level     <= w_level_next;
            press_pulse   <= w_press & en;
            release_pulse <= w_release & en;
            repeat_pulse  <= w_repeat & en;
            step_pulse    <= (w_press | w_repeat) & en;
        end
    end

endmodule
